// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the write_back / multi-cycle-unit regfile write arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic        valid;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } fifo_entry_t;

  localparam int WB_ARB_DEPTH = 2;
  localparam int FIFO_CNT_W   = 2;
  localparam int PTR_W        = 1;
  localparam int STARVE_CNT_W = 4;

  function automatic logic entry_hit(input fifo_entry_t e, input logic [4:0] addr);
    return e.valid && (e.waddr == addr);
  endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// Two-entry in-order buffer for mdu results, with an address-match invalidate port
// used when a younger pipe write targets the same register.
module wb_arb_fifo
  import wb_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  fifo_entry_t           push_entry,
  input  logic                  pop,
  input  logic                  inv_en,
  input  logic [4:0]            inv_addr,
  output fifo_entry_t           head,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  full
);

  fifo_entry_t           mem_r [WB_ARB_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [FIFO_CNT_W-1:0] count_r;

  // Storage, pointers and occupancy; push never targets the popped slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WB_ARB_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      for (int i = 0; i < WB_ARB_DEPTH; i++) begin
        if (inv_en && entry_hit(mem_r[i], inv_addr)) begin
          mem_r[i].valid <= 1'b0;
        end
      end
      if (pop) begin
        mem_r[rd_ptr_r].valid <= 1'b0;
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (push) begin
        mem_r[wr_ptr_r] <= push_entry;
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + FIFO_CNT_W'(1);
        2'b01:   count_r <= count_r - FIFO_CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head view; an empty FIFO never presents a valid head.
  always_comb begin
    head = mem_r[rd_ptr_r];
    if (count_r == FIFO_CNT_W'(0)) begin
      head.valid = 1'b0;
    end else begin
      head.valid = mem_r[rd_ptr_r].valid;
    end
  end

  assign count = count_r;
  assign full  = (count_r == FIFO_CNT_W'(WB_ARB_DEPTH));

endmodule

// File: rtl/wb_write_arbiter.sv
// Single regfile write port shared by write_back and buffered mdu results.
// Optional starvation guard (FORCE state, stall_req) enabled by WB_ARB_STARVE_GUARD_EN.
module wb_write_arbiter
  import wb_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_waddr,
  input  logic [31:0] mdu_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_req
);

  fifo_entry_t           head_s;
  fifo_entry_t           push_entry_s;
  logic [FIFO_CNT_W-1:0] fifo_count_s;
  logic [FIFO_CNT_W-1:0] count_next_s;
  logic                  fifo_full_s;
  logic                  in_force_s;
  logic                  pipe_win_s;
  logic                  head_win_s;
  logic                  pop_s;
  logic                  push_s;
  arb_state_e            state_r;
  logic                  rf_we_r;
  logic [4:0]            rf_waddr_r;
  logic [31:0]           rf_wdata_r;

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);
  logic [STARVE_CNT_W-1:0] starve_cnt_r;
  logic                    stall_req_r;
  assign in_force_s = (state_r == ST_FORCE);
  assign stall_req  = stall_req_r;
`else
  logic unused_limit_s;
  assign unused_limit_s = (STARVE_LIMIT != 32'sd0);
  assign in_force_s     = 1'b0;
  assign stall_req      = 1'b0;
`endif

  assign mdu_ready = !fifo_full_s;
  assign rf_we     = rf_we_r;
  assign rf_waddr  = rf_waddr_r;
  assign rf_wdata  = rf_wdata_r;

  // Port arbitration; a younger pipe write to the same register kills the mdu result.
  always_comb begin
    pipe_win_s = pipe_we && (pipe_waddr != 5'd0) && !in_force_s;
    head_win_s = head_s.valid && !pipe_win_s;
    if (fifo_count_s != FIFO_CNT_W'(0)) begin
      pop_s = head_win_s || !head_s.valid;
    end else begin
      pop_s = 1'b0;
    end
    push_s = mdu_valid && mdu_ready && (mdu_waddr != 5'd0) &&
             !(pipe_win_s && (pipe_waddr == mdu_waddr));
    push_entry_s = '{valid: 1'b1, waddr: mdu_waddr, wdata: mdu_wdata};
    count_next_s = fifo_count_s + FIFO_CNT_W'(push_s) - FIFO_CNT_W'(pop_s);
  end

  wb_arb_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .inv_en     (pipe_win_s),
    .inv_addr   (pipe_waddr),
    .head       (head_s),
    .count      (fifo_count_s),
    .full       (fifo_full_s)
  );

  // Arbiter FSM with registered regfile port and stall request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      rf_we_r    <= 1'b0;
      rf_waddr_r <= 5'd0;
      rf_wdata_r <= 32'd0;
`ifdef WB_ARB_STARVE_GUARD_EN
      starve_cnt_r <= '0;
      stall_req_r  <= 1'b0;
`endif
    end else begin
      rf_we_r <= pipe_win_s || head_win_s;
      if (pipe_win_s) begin
        rf_waddr_r <= pipe_waddr;
        rf_wdata_r <= pipe_wdata;
      end else if (head_win_s) begin
        rf_waddr_r <= head_s.waddr;
        rf_wdata_r <= head_s.wdata;
      end else begin
        rf_waddr_r <= 5'd0;
        rf_wdata_r <= 32'd0;
      end
      case (state_r)
        ST_IDLE: begin
          state_r <= (count_next_s != FIFO_CNT_W'(0)) ? ST_WAIT : ST_IDLE;
`ifdef WB_ARB_STARVE_GUARD_EN
          starve_cnt_r <= '0;
          stall_req_r  <= 1'b0;
`endif
        end
        ST_WAIT: begin
`ifdef WB_ARB_STARVE_GUARD_EN
          // A pop resolves starvation even when the limit was already reached.
          if (count_next_s == FIFO_CNT_W'(0)) begin
            state_r      <= ST_IDLE;
            starve_cnt_r <= '0;
            stall_req_r  <= 1'b0;
          end else if (pop_s) begin
            state_r      <= ST_WAIT;
            starve_cnt_r <= '0;
            stall_req_r  <= 1'b0;
          end else if (starve_cnt_r >= LIMIT_C) begin
            state_r      <= ST_FORCE;
            starve_cnt_r <= '0;
            stall_req_r  <= 1'b1;
          end else if (pipe_win_s && head_s.valid) begin
            state_r      <= ST_WAIT;
            starve_cnt_r <= starve_cnt_r + STARVE_CNT_W'(1);
            stall_req_r  <= 1'b0;
          end else begin
            state_r      <= ST_WAIT;
            starve_cnt_r <= starve_cnt_r;
            stall_req_r  <= 1'b0;
          end
`else
          state_r <= (count_next_s != FIFO_CNT_W'(0)) ? ST_WAIT : ST_IDLE;
`endif
        end
        ST_FORCE: begin
`ifdef WB_ARB_STARVE_GUARD_EN
          state_r      <= (count_next_s != FIFO_CNT_W'(0)) ? ST_WAIT : ST_IDLE;
          starve_cnt_r <= '0;
          stall_req_r  <= 1'b0;
`else
          state_r <= ST_IDLE;
`endif
        end
        default: begin
          state_r <= ST_IDLE;
`ifdef WB_ARB_STARVE_GUARD_EN
          starve_cnt_r <= '0;
          stall_req_r  <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule
